// File: rtl/gpiophy_link_emu.sv
// ---------------------------------------------------------------------------
// gpiophy_link_emu : multi-lane GPIO PHY loopback with bring-up FSM and delay line
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpiophy_link_emu #(
   parameter int NUM_CH        = 2,
   parameter int PHY_WIDTH     = 20,
   parameter int MAX_DELAY     = 64,
   parameter int RATE          = 2,
   parameter int SETTLE_CYCLES = 16,
   parameter int EN_WIDTH      = 4
) (
   input  logic                           clk_wr,
   input  logic                           rst_wr,
   input  logic [NUM_CH*PHY_WIDTH-1:0]    tx_data,
   input  logic [NUM_CH-1:0]              ch_en,
   input  logic [EN_WIDTH-1:0]            transfer_en,
   input  logic [15:0]                    delay_value,
   output logic [NUM_CH*PHY_WIDTH-1:0]    rx_data,
   output logic                           link_online,
   output logic [1:0]                     link_state,
   output logic [$clog2(MAX_DELAY)-1:0]   eff_delay,
   output logic                           delay_clamped
);

   localparam int c_W  = NUM_CH * PHY_WIDTH;
   localparam int c_DW = $clog2(MAX_DELAY);
   localparam int c_SH = (RATE == 4) ? 2 : ((RATE == 2) ? 1 : 0);
   localparam int c_CW = $clog2((MAX_DELAY > SETTLE_CYCLES) ? MAX_DELAY : SETTLE_CYCLES) + 1;
   localparam logic [15:0]     c_MAX_EFF16 = 16'(MAX_DELAY - 1);
   localparam logic [c_DW-1:0] c_MAX_EFF   = c_DW'(MAX_DELAY - 1);

   typedef enum logic [1:0] {
      ST_WAIT_EN = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_ONLINE  = 2'd2,
      ST_DRAIN   = 2'd3
   } state_t;

   state_t            r_state, w_next;
   logic [c_CW-1:0]   r_cnt, w_cnt_next;
   logic              w_latch;
   logic              w_all_en;
   logic [15:0]       r_dsync1, r_dsync2;
   logic [15:0]       w_req;
   logic              w_clamp;
   logic [c_DW-1:0]   w_eff;
   logic [c_DW-1:0]   r_eff;
   logic              r_clamp;
   logic [c_DW-1:0]   r_wptr;
   logic [c_DW-1:0]   w_rptr;
   logic [c_W-1:0]    r_mem [MAX_DELAY];
   logic [MAX_DELAY-1:0] r_valid;
   logic [c_W-1:0]    w_wdata;
   logic [c_W-1:0]    w_rd;
   logic [c_W-1:0]    r_rx;

   assign w_all_en = &transfer_en;
   assign w_req    = r_dsync2 >> c_SH;
   assign w_clamp  = (w_req > c_MAX_EFF16);
   assign w_eff    = w_clamp ? c_MAX_EFF : w_req[c_DW-1:0];

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_latch    = 1'b0;
      case (r_state)
         ST_WAIT_EN: begin
            if (w_all_en) begin
               w_next     = ST_SETTLE;
               w_cnt_next = '0;
               w_latch    = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (!w_all_en) begin
               w_next     = ST_WAIT_EN;
               w_cnt_next = '0;
            end else if (r_cnt == c_CW'(SETTLE_CYCLES - 1)) begin
               w_next     = ST_ONLINE;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt + c_CW'(1);
            end
         end
         ST_ONLINE: begin
            if (!w_all_en) begin
               w_next     = ST_DRAIN;
               w_cnt_next = '0;
            end
         end
         ST_DRAIN: begin
            // Full lap of zero writes scrubs every entry before the next session
            if (r_cnt == c_CW'(MAX_DELAY - 1)) begin
               w_next     = ST_WAIT_EN;
               w_cnt_next = '0;
            end else begin
               w_cnt_next = r_cnt + c_CW'(1);
            end
         end
         default: begin
            w_next     = ST_WAIT_EN;
            w_cnt_next = '0;
         end
      endcase
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      assign w_wdata[i*PHY_WIDTH +: PHY_WIDTH] =
         ((r_state == ST_ONLINE) && ch_en[i]) ? tx_data[i*PHY_WIDTH +: PHY_WIDTH] : '0;
   end

   // Zero delay needs the word being written this cycle, not the stored one
   assign w_rptr = r_wptr - r_eff;
   assign w_rd   = (r_eff == '0) ? w_wdata :
                   (r_valid[w_rptr] ? r_mem[w_rptr] : '0);

   always_ff @(posedge clk_wr) begin
      r_mem[r_wptr] <= w_wdata;
   end

   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         r_state  <= ST_WAIT_EN;
         r_cnt    <= '0;
         r_dsync1 <= '0;
         r_dsync2 <= '0;
         r_eff    <= '0;
         r_clamp  <= 1'b0;
         r_wptr   <= '0;
         r_valid  <= '0;
         r_rx     <= '0;
      end else begin
         r_state         <= w_next;
         r_cnt           <= w_cnt_next;
         r_dsync1        <= delay_value;
         r_dsync2        <= r_dsync1;
         r_wptr          <= r_wptr + c_DW'(1);
         r_valid[r_wptr] <= 1'b1;
         if (w_latch) begin
            r_eff   <= w_eff;
            r_clamp <= w_clamp;
         end
         r_rx <= (w_next == ST_ONLINE) ? w_rd : '0;
      end
   end

   assign rx_data       = r_rx;
   assign link_online   = (r_state == ST_ONLINE);
   assign link_state    = r_state;
   assign eff_delay     = r_eff;
   assign delay_clamped = r_clamp;

endmodule

`default_nettype wire

// File: tb/tb_gpiophy_link_emu.sv
// ---------------------------------------------------------------------------
// tb_gpiophy_link_emu : scoreboard bench with a cycle-history reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gpiophy_link_emu;

   localparam int NC = 2;
   localparam int PW = 20;
   localparam int MD = 64;
   localparam int RT = 2;
   localparam int SC = 16;
   localparam int EW = 4;
   localparam int W  = NC * PW;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  tx;
   logic [NC-1:0] chen;
   logic [EW-1:0] te;
   logic [15:0]   dv;
   logic [W-1:0]  rx_data;
   logic          link_online;
   logic [1:0]    link_state;
   logic [5:0]    eff_delay;
   logic          delay_clamped;

   always #5 clk = ~clk;

   gpiophy_link_emu #(
      .NUM_CH(NC), .PHY_WIDTH(PW), .MAX_DELAY(MD), .RATE(RT),
      .SETTLE_CYCLES(SC), .EN_WIDTH(EW)
   ) dut (
      .clk_wr(clk), .rst_wr(rst), .tx_data(tx), .ch_en(chen),
      .transfer_en(te), .delay_value(dv), .rx_data(rx_data),
      .link_online(link_online), .link_state(link_state),
      .eff_delay(eff_delay), .delay_clamped(delay_clamped)
   );

   typedef struct packed {
      logic [W-1:0] rx;
      logic [1:0]   st;
      logic         on;
      logic [5:0]   eff;
      logic         clamp;
   } exp_t;

   exp_t         sbq[$];
   int           n_cmp = 0;
   int           n_bad = 0;

   // Reference model: link phase, settle/drain counters, and the history of words written per cycle
   int           m_st, m_cnt, m_eff;
   bit           m_clamp;
   logic [15:0]  m_s1, m_s2;
   logic [W-1:0] hist[$];
   int           data_mode;
   int           ctr;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      exp_t         e;
      logic [W-1:0] word;
      int           req;
      e = '0;
      if (rst) begin
         m_st = 0; m_cnt = 0; m_eff = 0; m_clamp = 0; m_s1 = '0; m_s2 = '0;
         hist = {};
         for (int i = 0; i < MD; i++) hist.push_back('0);
      end else begin
         word = '0;
         if (m_st == 2)
            for (int i = 0; i < NC; i++)
               if (chen[i]) word[i*PW +: PW] = tx[i*PW +: PW];
         hist.push_front(word);
         void'(hist.pop_back());
         case (m_st)
            0: if (te == '1) begin
                  m_st = 1; m_cnt = 0;
                  req = int'(m_s2) / RT;
                  m_clamp = (req > MD - 1);
                  m_eff = m_clamp ? MD - 1 : req;
               end
            1: if (te != '1) begin m_st = 0; m_cnt = 0; end
               else if (m_cnt == SC - 1) begin m_st = 2; m_cnt = 0; end
               else m_cnt++;
            2: if (te != '1) begin m_st = 3; m_cnt = 0; end
            default: if (m_cnt == MD - 1) begin m_st = 0; m_cnt = 0; end
                     else m_cnt++;
         endcase
         m_s2 = m_s1;
         m_s1 = dv;
         e.rx = (m_st == 2) ? hist[m_eff] : '0;
      end
      e.st    = 2'(m_st);
      e.on    = (m_st == 2);
      e.eff   = 6'(m_eff);
      e.clamp = m_clamp;
      sbq.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      case (data_mode)
         0: tx = W'({$urandom(), $urandom()});
         1: begin ctr++; tx = {PW'(ctr + 100000), PW'(ctr)}; end
         default: tx = {20'h12345, 20'h12345};
      endcase
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("rx_data",       rx_data,       e.rx);
         check("link_state",    W'(link_state), W'(e.st));
         check("link_online",   W'(link_online), W'(e.on));
         check("eff_delay",     W'(eff_delay), W'(e.eff));
         check("delay_clamped", W'(delay_clamped), W'(e.clamp));
      end
   end

   initial begin
      rst = 1'b1; te = '0; dv = '0; chen = '1; tx = '0; data_mode = 0; ctr = 0;
      run(4);
      check("reset_state", W'(link_state), '0);
      rst = 1'b0;

      // Rate-scaled delay: 10 full-rate cycles -> 5
      dv = 16'd10; run(3);
      te = '1; run(SC + 2);
      check("eff_rate2", W'(eff_delay), W'(5));
      run(100);
      te = 4'b1110; run(MD + 5);

      // Zero delay, then clamped delay
      dv = 16'd0; run(3);
      te = '1; run(SC + 2);
      check("eff_zero", W'({eff_delay, delay_clamped}), '0);
      run(50);
      te = '0; run(MD + 5);
      dv = 16'd500; run(3);
      te = '1; run(SC + 2);
      check("eff_clamp", W'({eff_delay, delay_clamped}), W'({6'd63, 1'b1}));
      run(150);
      te = '0; run(MD + 5);

      // Enable drops exactly when settle would complete
      te = '1; run(SC);
      te = 4'b1011; run(3);
      check("abort_offline", W'(link_online), '0);

      // Counter stream with eff=8, drain, relink with eff=2
      data_mode = 1; dv = 16'd16; run(3);
      te = '1; run(SC + 62);
      te = '0; run(MD + 4);
      dv = 16'd4; run(3);
      te = '1; run(SC + 32);
      te = '0; run(MD + 4);

      // Lane masking then reset mid-stream
      data_mode = 2; chen = 2'b01; dv = 16'd6; run(3);
      te = '1; run(SC + 22);
      rst = 1'b1; run(1);
      check("rst_state",  W'(link_state), '0);
      check("rst_rx",     rx_data, '0);
      rst = 1'b0; chen = '1; te = '0; data_mode = 0;
      run(2);

      // Randomised operation
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0)
            te = ($urandom_range(0, 3) == 0) ? EW'($urandom()) : '1;
         if ($urandom_range(0, 49) == 0) dv = 16'($urandom_range(0, 300));
         if ($urandom_range(0, 39) == 0) chen = NC'($urandom());
         rst = ($urandom_range(0, 999) == 0);
         step();
      end
      rst = 1'b0;
      run(2);
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
